inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the instruction decode unit: takes decoded RV32I fields (rd, rs1, rs2, imm, alu_op, com_op, inst_type) and packs them into a 32-bit instruction word, flagging unencodable fields.
- Used by the self-test/trap injector and the bench stimulus path to generate instruction words that feed the decoder's inst_in.
- Encoded words are buffered in a small in-order FIFO. Requests and responses use valid/ready handshakes.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- REG_W_END, 31, instruction/immediate MSB (from reg_defines.vh)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- reqValid  in  1  request fields valid
- reqReady  out  1  encoder can accept a request this cycle
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  full sign-extended immediate, same value the decoder would produce
- alu_op  in  ALU_OP_END+1  same encoding as decoder output
- com_op  in  COM_OP_END+1  branch compare op (funct3)
- inst_type  in  INST_TYPE_END+1  same encoding as decoder output
- respValid  out  1  head of FIFO valid
- respReady  in  1  consumer takes head this cycle
- inst_out  out  32  encoded instruction at FIFO head
- err  out  1  head entry unencodable

Behaviour:
- Reset (async, reset==0): FIFO empty, pointers/count 0, respValid=0, inst_out=0, err=0, reqReady=1.
- reqReady = (count != DEPTH), computed from registered count only. A pop in the same cycle does not free a slot until the next cycle.
- Accept: reqValid&reqReady at a rising edge. The encoded {err,inst} is written to the tail.
- Latency: accept at edge N, entry visible at head with respValid=1 after edge N when the FIFO was empty.
- Pop: respValid&respReady removes the head. Order is strictly FIFO.
- Simultaneous push and pop with a non-full FIFO: both occur and count is unchanged.
- Pointers wrap modulo DEPTH.
- Encoding by inst_type:
  - IMM: opcode 0010011, funct3=alu_op[2:0], inst[31:20]=imm[11:0]. For funct3 001/101: inst[31:25]={1'b0,alu_op[3],5'b0}, inst[24:20]=imm[4:0].
  - REG: opcode 0110011, funct3=alu_op[2:0], funct7={1'b0,alu_op[3],5'b0}.
  - LOAD: opcode 0000011, funct3=inst_type[2:0], I-imm.
  - STORE: opcode 0100011, funct3=inst_type[2:0], S-imm split {imm[11:5]} / {imm[4:0]}.
  - UPP: opcode 0110111. AUIPC: opcode 0010111. Both use inst[31:12]=imm[31:12].
  - JUMP: opcode 1101111, J-imm {imm[20],imm[10:1],imm[11],imm[19:12]}.
  - JUMPR: opcode 1100111, funct3 000, I-imm.
  - BRANCH: opcode 1100011, funct3=com_op, B-imm {imm[12],imm[10:5]} / {imm[4:1],imm[11]}.
  - SYSTEM: opcode 1110011, funct3={inst_type[2],alu_op[2],alu_op[3]}, I-imm.
  - Any other inst_type: err=1.
- Unused fields are zero: rs2 for I/U/J types; rs1 for U/J types; rd for S/B types.
- Error entries: inst=32'h0000_0000, err=1. They still occupy a FIFO slot and pop normally.
- reset deassert mid-stream: async assert clears the FIFO immediately. Entries in flight are discarded.

Optional Feature:
- INST_ENC_CHECK_EN defined: range/alignment checks raise err.
  - I/S imm must equal sign-extension of imm[11:0].
  - Shift imm[31:5] must be 0.
  - B imm must fit 13-bit signed with imm[0]=0.
  - J imm must fit 21-bit signed with imm[0]=0.
  - U imm must have imm[11:0]=0.
- INST_ENC_CHECK_EN undefined: only an unknown inst_type sets err. Other fields are silently truncated to their encodable bits.

Decomposition:
- Shared package isa_pkg holds:
  - OPCODE_* constants, now shared with the decoder
  - FUNCT3_SR, FUNCT3_ADD
  - funct7 constants
  - an enc_entry_t struct {err, inst[31:0]}
- ALU/COM/INST encodings stay in the existing defines headers.
- One sub-module, inst_enc_fifo: parameterised DEPTH FIFO of enc_entry_t with count, full/empty and an async active-low reset.
- Encoding logic is a combinational always_comb block in inst_encoder.

Test Plan:
- Basic I-type: INST_IMM, alu_op=ADD, rd=1, rs1=2, imm=32'hFFFF_FFFF, respReady=1 → one cycle later respValid=1, inst_out=32'hFFF1_0093, err=0.
- REG sub: INST_REG, alu_op={1,000}, rd=3, rs1=1, rs2=2 → 32'h4020_81B3.
- U and B types:
  - lui rd=5, imm=32'h1234_5000 → 32'h1234_52B7.
  - BRANCH com_op=000, rs1=1, rs2=2, imm=-4 → 32'hFE20_8EE3.
  - SYSTEM with funct3 bits 000 and imm=0 → 32'h0000_0073.
- Error path:
  - With INST_ENC_CHECK_EN: BRANCH imm=3 → err=1, inst_out=0.
  - Without INST_ENC_CHECK_EN: the same request gives err=0, inst_out=32'h0000_0163 (imm[0] dropped, imm[4:1]=0001 lands in inst[11:8]).
  - Unknown inst_type → err=1 in both builds.
- Back-pressure, DEPTH=2, respReady=0, three back-to-back requests A,B,C:
  - reqReady drops after B is accepted; C is held.
  - Raise respReady: A pops, then reqReady rises on the next cycle and C is accepted.
  - Output order is A, B, C.
- Reset mid-stream: two entries queued, pulse reset=0 asynchronously between edges → respValid=0, inst_out=0, err=0, reqReady=1 immediately; the next accepted request appears as the sole entry.

Source files
------------

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared RV32I encoding constants for the instruction decoder and
// inst_encoder.
//
// Contents:
//   - OPCODE_*            7-bit major opcodes
//   - FUNCT3_* / FUNCT7_* function-field constants
//   - ALU_/COM_/INST_*    decoded field encodings, identical to the
//                         decoder outputs
//   - enc_entry_t         one encoder FIFO entry {err, inst}
//   - fits_signed()       range helper used by the optional field checks
//
// inst_type layout: [6:3] selects the instruction class. [2:0] carries the
// funct3 sub-code for loads and stores, and bit 2 also feeds SYSTEM funct3.
// -----------------------------------------------------------------------------
package isa_pkg;

  localparam int ALU_OP_END    = 3;
  localparam int COM_OP_END    = 2;
  localparam int INST_TYPE_END = 6;

  localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_REG    = 7'b0110011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // alu_op = {alt, funct3}; alt selects SUB / SRA
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [2:0] COM_BEQ = 3'b000;
  localparam logic [2:0] COM_BNE = 3'b001;

  typedef enum logic [3:0] {
    INST_CLS_IMM    = 4'd0,
    INST_CLS_REG    = 4'd1,
    INST_CLS_LOAD   = 4'd2,
    INST_CLS_STORE  = 4'd3,
    INST_CLS_UPP    = 4'd4,
    INST_CLS_AUIPC  = 4'd5,
    INST_CLS_JUMP   = 4'd6,
    INST_CLS_JUMPR  = 4'd7,
    INST_CLS_BRANCH = 4'd8,
    INST_CLS_SYSTEM = 4'd9
  } inst_cls_e;

  localparam logic [6:0] INST_IMM    = 7'b0000_000;
  localparam logic [6:0] INST_REG    = 7'b0001_000;
  localparam logic [6:0] INST_LW     = 7'b0010_010;
  localparam logic [6:0] INST_SW     = 7'b0011_010;
  localparam logic [6:0] INST_UPP    = 7'b0100_000;
  localparam logic [6:0] INST_AUIPC  = 7'b0101_000;
  localparam logic [6:0] INST_JUMP   = 7'b0110_000;
  localparam logic [6:0] INST_JUMPR  = 7'b0111_000;
  localparam logic [6:0] INST_BRANCH = 7'b1000_000;
  localparam logic [6:0] INST_SYSTEM = 7'b1001_000;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_entry_t;

  // True when every bit above msb is a copy of bit msb, i.e. the value is a
  // correctly sign-extended (msb+1)-bit signed number.
  function automatic logic fits_signed(input logic [31:0] value, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i > msb) && (value[i] != value[msb])) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// -----------------------------------------------------------------------------
// inst_enc_fifo
// In-order FIFO of enc_entry_t holding encoded instruction words.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset, empties the FIFO
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   entry to write
//   pop        in   remove the head (ignored when empty)
//   head       out  entry at the head, all zero when empty
//   full       out  count == DEPTH, taken from the registered count only
//   empty      out  count == 0
//
// DEPTH must be a power of two so that the pointers wrap naturally.
// -----------------------------------------------------------------------------
module inst_enc_fifo
  import isa_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  enc_entry_t push_data,
  input  logic       pop,
  output enc_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  enc_entry_t       mem_r [DEPTH];

  logic push_ok_s;
  logic pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so nothing stale survives it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{err: 1'b0, inst: 32'h0000_0000};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Head view; a drained slot keeps old data, so mask it while empty
  always_comb begin
    if (empty) begin
      head = '{err: 1'b0, inst: 32'h0000_0000};
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Packs decoded RV32I fields back into a 32-bit instruction word and queues
// the result in an in-order FIFO. Unencodable requests produce an entry with
// err=1 and inst=0, which is still queued and popped like any other entry.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   reqValid   in   request fields valid
//   reqReady   out  a request can be accepted this cycle (FIFO not full)
//   rd/rs1/rs2 in   register indices
//   imm        in   full sign-extended immediate
//   alu_op     in   {alt, funct3}, decoder encoding
//   com_op     in   branch compare funct3
//   inst_type  in   {class[3:0], sub[2:0]}, decoder encoding
//   respValid  out  FIFO head valid
//   respReady  in   consumer takes the head this cycle
//   inst_out   out  encoded instruction at the FIFO head
//   err        out  head entry could not be encoded
//
// Build option:
//   INST_ENC_CHECK_EN  when defined, out-of-range or misaligned immediates
//                      also raise err. Otherwise only an unknown inst_type
//                      raises err and immediates are truncated.
// -----------------------------------------------------------------------------
module inst_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int REG_W_END = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [REG_W_END:0]       imm,
  input  logic [ALU_OP_END:0]      alu_op,
  input  logic [COM_OP_END:0]      com_op,
  input  logic [INST_TYPE_END:0]   inst_type,
  output logic                     respValid,
  input  logic                     respReady,
  output logic [REG_W_END:0]       inst_out,
  output logic                     err
);

  logic [3:0]  cls_s;
  logic [2:0]  f3_s;
  logic        shift_s;
  logic [6:0]  funct7_s;
  logic [31:0] raw_inst_s;
  logic        known_s;
  logic        range_ok_s;
  enc_entry_t  entry_s;
  enc_entry_t  head_s;
  logic        full_s;
  logic        empty_s;

  assign cls_s   = inst_type[INST_TYPE_END:3];
  assign f3_s    = alu_op[2:0];
  assign shift_s = (f3_s == FUNCT3_SLL) || (f3_s == FUNCT3_SR);

  // alt bit of alu_op selects SUB/SRA funct7
  always_comb begin
    if (alu_op[3]) begin
      funct7_s = FUNCT7_ALT;
    end else begin
      funct7_s = FUNCT7_BASE;
    end
  end

  // Field packing per instruction class; unused register fields stay zero
  always_comb begin
    raw_inst_s = 32'h0000_0000;
    known_s    = 1'b1;
    case (cls_s)
      INST_CLS_IMM: begin
        if (shift_s) begin
          raw_inst_s = {funct7_s, imm[4:0], rs1, f3_s, rd, OPCODE_IMM};
        end else begin
          raw_inst_s = {imm[11:0], rs1, f3_s, rd, OPCODE_IMM};
        end
      end
      INST_CLS_REG: begin
        raw_inst_s = {funct7_s, rs2, rs1, f3_s, rd, OPCODE_REG};
      end
      INST_CLS_LOAD: begin
        raw_inst_s = {imm[11:0], rs1, inst_type[2:0], rd, OPCODE_LOAD};
      end
      INST_CLS_STORE: begin
        raw_inst_s = {imm[11:5], rs2, rs1, inst_type[2:0], imm[4:0], OPCODE_STORE};
      end
      INST_CLS_UPP: begin
        raw_inst_s = {imm[31:12], rd, OPCODE_LUI};
      end
      INST_CLS_AUIPC: begin
        raw_inst_s = {imm[31:12], rd, OPCODE_AUIPC};
      end
      INST_CLS_JUMP: begin
        raw_inst_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
      end
      INST_CLS_JUMPR: begin
        raw_inst_s = {imm[11:0], rs1, FUNCT3_ADD, rd, OPCODE_JALR};
      end
      INST_CLS_BRANCH: begin
        raw_inst_s = {imm[12], imm[10:5], rs2, rs1, com_op, imm[4:1], imm[11],
                      OPCODE_BRANCH};
      end
      INST_CLS_SYSTEM: begin
        raw_inst_s = {imm[11:0], rs1, inst_type[2], alu_op[2], alu_op[3], rd,
                      OPCODE_SYSTEM};
      end
      default: begin
        raw_inst_s = 32'h0000_0000;
        known_s    = 1'b0;
      end
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  // Immediate must be representable in the target field without loss
  always_comb begin
    range_ok_s = 1'b1;
    case (cls_s)
      INST_CLS_IMM: begin
        if (shift_s) begin
          range_ok_s = (imm[31:5] == 27'd0);
        end else begin
          range_ok_s = fits_signed(imm, 11);
        end
      end
      INST_CLS_LOAD, INST_CLS_STORE, INST_CLS_JUMPR, INST_CLS_SYSTEM: begin
        range_ok_s = fits_signed(imm, 11);
      end
      INST_CLS_UPP, INST_CLS_AUIPC: begin
        range_ok_s = (imm[11:0] == 12'h000);
      end
      INST_CLS_JUMP: begin
        range_ok_s = fits_signed(imm, 20) && (imm[0] == 1'b0);
      end
      INST_CLS_BRANCH: begin
        range_ok_s = fits_signed(imm, 12) && (imm[0] == 1'b0);
      end
      default: begin
        range_ok_s = 1'b1;
      end
    endcase
  end
`else
  assign range_ok_s = 1'b1;
`endif

  // Error entries carry an all-zero word so a consumer never sees junk
  always_comb begin
    if (!known_s || !range_ok_s) begin
      entry_s = '{err: 1'b1, inst: 32'h0000_0000};
    end else begin
      entry_s = '{err: 1'b0, inst: raw_inst_s};
    end
  end

  inst_enc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (reqValid),
    .push_data (entry_s),
    .pop       (respReady),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // full_s comes from the registered count, so a same-cycle pop frees no slot
  assign reqReady  = ~full_s;
  assign respValid = ~empty_s;
  assign inst_out  = head_s.inst;
  assign err       = head_s.err;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  import isa_pkg::*;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic [2:0]  com_op;
  logic [6:0]  inst_type;
  logic        respValid;
  logic        respReady;
  logic [31:0] inst_out;
  logic        err;

  int total;
  int bad;

  inst_encoder #(.DEPTH(DEPTH), .REG_W_END(31)) dut (
    .clock     (clock),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .alu_op    (alu_op),
    .com_op    (com_op),
    .inst_type (inst_type),
    .respValid (respValid),
    .respReady (respReady),
    .inst_out  (inst_out),
    .err       (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference encoder: fields placed with shifts and masks, ranges checked
  // with signed integer bounds.
  function automatic logic [32:0] ref_enc(input logic [6:0] t, input logic [3:0] a,
                                          input logic [2:0] c, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] i);
    logic [31:0] w, rd_f, rs1_f, rs2_f, f3_f, sub_f, imm_i, alt_f;
    int          si;
    int          sys_f3;
    logic        known, in_range, r12;
    rd_f   = {27'd0, d} << 7;
    rs1_f  = {27'd0, s1} << 15;
    rs2_f  = {27'd0, s2} << 20;
    f3_f   = {29'd0, a[2:0]} << 12;
    sub_f  = {29'd0, t[2:0]} << 12;
    imm_i  = (i & 32'h0000_0FFF) << 20;
    alt_f  = a[3] ? 32'h4000_0000 : 32'h0000_0000;
    si     = $signed(i);
    r12    = (si >= -2048) && (si <= 2047);
    known  = 1'b1;
    in_range = 1'b1;
    w      = 32'h0;
    case (t[6:3])
      INST_CLS_IMM: begin
        if (a[2:0] == 3'd1 || a[2:0] == 3'd5) begin
          w = alt_f | ((i & 32'h1F) << 20) | rs1_f | f3_f | rd_f | 32'h13;
          in_range = ((i >> 5) == 32'd0);
        end else begin
          w = imm_i | rs1_f | f3_f | rd_f | 32'h13;
          in_range = r12;
        end
      end
      INST_CLS_REG:   w = alt_f | rs2_f | rs1_f | f3_f | rd_f | 32'h33;
      INST_CLS_LOAD:  begin w = imm_i | rs1_f | sub_f | rd_f | 32'h03; in_range = r12; end
      INST_CLS_STORE: begin
        w = (((i >> 5) & 32'h7F) << 25) | rs2_f | rs1_f | sub_f | ((i & 32'h1F) << 7) | 32'h23;
        in_range = r12;
      end
      INST_CLS_UPP:   begin w = (i & 32'hFFFF_F000) | rd_f | 32'h37; in_range = ((i % 4096) == 0); end
      INST_CLS_AUIPC: begin w = (i & 32'hFFFF_F000) | rd_f | 32'h17; in_range = ((i % 4096) == 0); end
      INST_CLS_JUMP: begin
        w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 32'h1) << 20)
            | (((i >> 12) & 32'hFF) << 12) | rd_f | 32'h6F;
        in_range = (si >= -(1 << 20)) && (si < (1 << 20)) && ((i % 2) == 0);
      end
      INST_CLS_JUMPR: begin w = imm_i | rs1_f | rd_f | 32'h67; in_range = r12; end
      INST_CLS_BRANCH: begin
        w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | rs2_f | rs1_f
            | ({29'd0, c} << 12) | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
        in_range = (si >= -4096) && (si <= 4095) && ((i % 2) == 0);
      end
      INST_CLS_SYSTEM: begin
        sys_f3 = 4 * int'(t[2]) + 2 * int'(a[2]) + int'(a[3]);
        w = imm_i | rs1_f | (32'(sys_f3) << 12) | rd_f | 32'h73;
        in_range = r12;
      end
      default: known = 1'b0;
    endcase
`ifdef INST_ENC_CHECK_EN
    if (!known || !in_range) return {1'b1, 32'h0};
`else
    if (!known) return {1'b1, 32'h0};
`endif
    return {1'b0, w};
  endfunction

  task automatic drive_req(input logic [6:0] t, input logic [3:0] a, input logic [2:0] c,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] i);
    inst_type = t; alu_op = a; com_op = c; rd = d; rs1 = s1; rs2 = s2; imm = i;
    reqValid = 1'b1;
  endtask

  // Sends one request into an empty FIFO with respReady=1, samples the head
  // one edge later, then lets it pop. Returns at a falling edge.
  task automatic send_one(input logic [6:0] t, input logic [3:0] a, input logic [2:0] c,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [31:0] i, output logic v, output logic [31:0] o,
                          output logic e);
    respReady = 1'b1;
    drive_req(t, a, c, d, s1, s2, i);
    @(posedge clock); #1;
    reqValid = 1'b0;
    v = respValid; o = inst_out; e = err;
    @(posedge clock); #1;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0; reqValid = 1'b0; respReady = 1'b0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h0; alu_op = 4'd0; com_op = 3'd0; inst_type = 7'd0;
    #2;
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL reset_respValid got=%b exp=0", respValid); end
    total++; if (inst_out !== 32'h0) begin bad++; $display("FAIL reset_inst_out got=%h exp=0", inst_out); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL reset_reqReady got=%b exp=1", reqReady); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_itype;
    logic v, e; logic [31:0] o;
    send_one(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, v, o, e);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", v); end
    total++; if (o !== 32'hFFF1_0093) begin bad++; $display("FAIL addi_inst got=%h exp=fff10093", o); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL addi_err got=%b exp=0", e); end
  endtask

  task automatic test_reg_sub;
    logic v, e; logic [31:0] o;
    send_one(INST_REG, ALU_SUB, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, v, o, e);
    total++; if (o !== 32'h4020_81B3 || e !== 1'b0 || v !== 1'b1) begin
      bad++; $display("FAIL reg_sub got=%b/%h exp=0/402081b3", e, o); end
  endtask

  task automatic test_u_b_sys;
    logic v, e; logic [31:0] o;
    send_one(INST_UPP, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, v, o, e);
    total++; if (o !== 32'h1234_52B7 || e !== 1'b0) begin
      bad++; $display("FAIL lui got=%b/%h exp=0/123452b7", e, o); end
    send_one(INST_BRANCH, 4'd0, COM_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, v, o, e);
    total++; if (o !== 32'hFE20_8EE3 || e !== 1'b0) begin
      bad++; $display("FAIL branch_neg got=%b/%h exp=0/fe208ee3", e, o); end
    send_one(INST_SYSTEM, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, v, o, e);
    total++; if (o !== 32'h0000_0073 || e !== 1'b0) begin
      bad++; $display("FAIL system got=%b/%h exp=0/00000073", e, o); end
  endtask

  task automatic test_error_path;
    logic v, e; logic [31:0] o;
    logic [32:0] exp_b;
`ifdef INST_ENC_CHECK_EN
    exp_b = {1'b1, 32'h0000_0000};
`else
    exp_b = {1'b0, 32'h0000_0163};
`endif
    send_one(INST_BRANCH, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3, v, o, e);
    total++; if ({e, o} !== exp_b) begin
      bad++; $display("FAIL branch_odd got=%h exp=%h", {e, o}, exp_b); end
    send_one(7'b1111_000, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'h10, v, o, e);
    total++; if (e !== 1'b1 || o !== 32'h0 || v !== 1'b1) begin
      bad++; $display("FAIL unknown_type got=%b/%b/%h exp=1/1/00000000", v, e, o); end
  endtask

  task automatic test_back_to_back;
    logic [32:0] ea, eb, ec;
    ea = ref_enc(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd1);
    eb = ref_enc(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd2);
    ec = ref_enc(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3);
    respReady = 1'b0;
    drive_req(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd1);
    @(posedge clock); #1;
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_a got=%b exp=1", reqReady); end
    @(negedge clock);
    drive_req(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd2);
    @(posedge clock); #1;
    total++; if (reqReady !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_b got=%b exp=0", reqReady); end
    @(negedge clock);
    drive_req(INST_IMM, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3);
    @(posedge clock); #1;
    total++; if (reqReady !== 1'b0) begin bad++; $display("FAIL b2b_c_held got=%b exp=0", reqReady); end
    total++; if ({err, inst_out} !== ea) begin bad++; $display("FAIL b2b_head_a got=%h exp=%h", {err, inst_out}, ea); end
    @(negedge clock);
    respReady = 1'b1;
    @(posedge clock); #1;
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL b2b_ready_rise got=%b exp=1", reqReady); end
    total++; if ({err, inst_out} !== eb) begin bad++; $display("FAIL b2b_head_b got=%h exp=%h", {err, inst_out}, eb); end
    @(posedge clock); #1;
    reqValid = 1'b0;
    total++; if (respValid !== 1'b1 || {err, inst_out} !== ec) begin
      bad++; $display("FAIL b2b_head_c got=%b/%h exp=1/%h", respValid, {err, inst_out}, ec); end
    @(posedge clock); #1;
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", respValid); end
    @(negedge clock);
  endtask

  task automatic test_reset_midstream;
    logic [32:0] ed;
    ed = ref_enc(INST_UPP, 4'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
    respReady = 1'b0;
    drive_req(INST_REG, ALU_ADD, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    @(posedge clock);
    @(negedge clock);
    drive_req(INST_REG, ALU_SUB, 3'd0, 5'd4, 5'd5, 5'd6, 32'h0);
    @(posedge clock); #1;
    reqValid = 1'b0;
    total++; if (reqReady !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", reqReady); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL mid_respValid got=%b exp=0", respValid); end
    total++; if (inst_out !== 32'h0) begin bad++; $display("FAIL mid_inst_out got=%h exp=0", inst_out); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err); end
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL mid_reqReady got=%b exp=1", reqReady); end
    reset = 1'b1;
    @(negedge clock);
    respReady = 1'b1;
    drive_req(INST_UPP, 4'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
    @(posedge clock); #1;
    reqValid = 1'b0;
    total++; if (respValid !== 1'b1 || {err, inst_out} !== ed) begin
      bad++; $display("FAIL mid_after got=%b/%h exp=1/%h", respValid, {err, inst_out}, ed); end
    @(posedge clock); #1;
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL mid_sole got=%b exp=0", respValid); end
    @(negedge clock);
  endtask

  task automatic test_random;
    logic [32:0] exp_q[$];
    logic [32:0] nxt;
    logic [31:0] r;
    logic        acc, pop;
    for (int n = 0; n < 400; n++) begin
      total++; if (respValid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, respValid, exp_q.size() != 0); end
      total++; if (reqReady !== (exp_q.size() != DEPTH)) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, reqReady, exp_q.size() != DEPTH); end
      if (exp_q.size() != 0) begin
        total++; if ({err, inst_out} !== exp_q[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", n, {err, inst_out}, exp_q[0]); end
      end
      r = $urandom();
      inst_type = {r[3:0], r[6:4]};
      alu_op = r[10:7]; com_op = r[13:11]; rd = r[18:14]; rs1 = r[23:19]; rs2 = r[28:24];
      r = $urandom();
      if (r[0]) imm = $urandom();
      else imm = 32'($signed(r[14:1])) & ~32'(r[15]);
      reqValid = ($urandom_range(0, 3) != 0);
      respReady = ($urandom_range(0, 2) != 0);
      nxt = ref_enc(inst_type, alu_op, com_op, rd, rs1, rs2, imm);
      acc = reqValid && (exp_q.size() != DEPTH);
      pop = respReady && (exp_q.size() != 0);
      @(posedge clock);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(nxt);
      @(negedge clock);
    end
    reqValid = 1'b0;
    respReady = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%b exp=0", respValid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_itype;
    test_reg_sub;
    test_u_b_sys;
    test_error_path;
    test_back_to_back;
    test_reset_midstream;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
